// File: rtl/ibex_pkg.sv
// ibex_pkg: shared types for the RVFI trace buffer (record layout, record kind, capture FSM state).
package ibex_pkg;

   typedef enum logic {
      TRACE_RETIRE,
      TRACE_OVERFLOW
   } trace_kind_e;

   typedef enum logic {
      TRACE_CAPTURE,
      TRACE_DROPPING
   } trace_state_e;

   typedef struct packed {
      trace_kind_e kind;
      logic        trap;
      logic        intr;
      logic [63:0] order;
      logic [31:0] pc;
      logic [31:0] insn;
      logic [4:0]  rd_addr;
      logic [31:0] rd_wdata;
      logic [31:0] mem_addr;
      logic [3:0]  rmask;
      logic [3:0]  wmask;
   } trace_rec_t;

endpackage

// File: rtl/ibex_trace_fifo.sv
// ibex_trace_fifo: generic first-word-fall-through synchronous FIFO.
// Ports: clk_i/rst_ni clock and async active-low reset; flush_i synchronous clear (wins over push/pop);
//        push_i/wdata_i write side; pop_i/rdata_o read side (rdata_o is the head, zero when empty);
//        full_o/empty_o/fill_o occupancy status.
module ibex_trace_fifo #(
   parameter int unsigned Depth = 8,
   parameter type         T     = logic
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   flush_i,
   input  logic                   push_i,
   input  T                       wdata_i,
   input  logic                   pop_i,
   output T                       rdata_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(Depth):0] fill_o
);

   localparam int unsigned PtrW = $clog2(Depth);

   T               mem [Depth];
   logic [PtrW-1:0] wptr, rptr;
   logic           do_push, do_pop;

   assign empty_o = fill_o == '0;
   assign full_o  = fill_o == (PtrW+1)'(Depth);
   assign do_pop  = pop_i && !empty_o && !flush_i;
   // A pop in the same cycle frees the slot the push needs.
   assign do_push = push_i && (!full_o || do_pop) && !flush_i;
   assign rdata_o = empty_o ? '0 : mem[rptr];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni || flush_i) begin
         wptr   <= '0;
         rptr   <= '0;
         fill_o <= '0;
         for (int i = 0; i < Depth; i++) mem[i] <= '0;
      end else begin
         if (do_push) begin
            mem[wptr] <= wdata_i;
            wptr      <= wptr + 1'b1;
         end
         if (do_pop) rptr <= rptr + 1'b1;
         fill_o <= fill_o + (PtrW+1)'(do_push) - (PtrW+1)'(do_pop);
      end
   end

endmodule

// File: rtl/ibex_rvfi_trace_buffer.sv
// ibex_rvfi_trace_buffer: captures RVFI retirements as trace records, buffers them and streams them out,
// replacing runs of dropped retirements with a single overflow marker.
// Ports: clk_i/rst_ni clock and async active-low reset; enable_i capture enable; flush_i synchronous clear;
//        rvfi_* retirement port; trace_valid_o/trace_ready_i/trace_rec_o output stream;
//        fill_o FIFO occupancy; drop_total_o saturating count of dropped retirements.
module ibex_rvfi_trace_buffer
   import ibex_pkg::*;
#(
   parameter int unsigned Depth        = 8,
   parameter int unsigned DropCntWidth = 16
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   enable_i,
   input  logic                   flush_i,
   input  logic                   rvfi_valid,
   input  logic [63:0]            rvfi_order,
   input  logic [31:0]            rvfi_insn,
   input  logic                   rvfi_trap,
   input  logic                   rvfi_intr,
   input  logic [31:0]            rvfi_pc_rdata,
   input  logic [4:0]             rvfi_rd_addr,
   input  logic [31:0]            rvfi_rd_wdata,
   input  logic [31:0]            rvfi_mem_addr,
   input  logic [3:0]             rvfi_mem_rmask,
   input  logic [3:0]             rvfi_mem_wmask,
   output logic                   trace_valid_o,
   input  logic                   trace_ready_i,
   output trace_rec_t             trace_rec_o,
   output logic [$clog2(Depth):0] fill_o,
   output logic [31:0]            drop_total_o
);

   trace_state_e            state_q, state_d;
   logic [DropCntWidth-1:0] gap_cnt_q;
   logic [63:0]             gap_order_q;
   trace_rec_t              rec;
   logic                    full, empty, pop, push, push_ok, cap, drop;

   assign cap           = enable_i && rvfi_valid;
   assign trace_valid_o = !empty;
   assign pop           = trace_valid_o && trace_ready_i;
   assign push_ok       = !full || pop;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= TRACE_CAPTURE;
      else         state_q <= flush_i ? TRACE_CAPTURE : state_d;
   end

   always_comb begin
      state_d = state_q;
      if (state_q == TRACE_CAPTURE && drop) state_d = TRACE_DROPPING;
      if (state_q == TRACE_DROPPING && push) state_d = TRACE_CAPTURE;
   end

   // While dropping, the marker only goes out in a cycle with no accepted retirement,
   // so a retirement is never silently lost between the gap and the marker.
   always_comb begin
      push = push_ok && (state_q == TRACE_CAPTURE ? cap : !cap);
      drop = cap && (state_q == TRACE_DROPPING || !push_ok);
      rec  = '0;
      if (state_q == TRACE_DROPPING) begin
         rec.kind     = TRACE_OVERFLOW;
         rec.order    = gap_order_q;
         rec.rd_wdata = 32'(gap_cnt_q);
      end else begin
         rec.kind     = TRACE_RETIRE;
         rec.trap     = rvfi_trap;
         rec.intr     = rvfi_intr;
         rec.order    = rvfi_order;
         rec.pc       = rvfi_pc_rdata;
         rec.insn     = rvfi_insn;
         rec.rd_addr  = rvfi_rd_addr;
         rec.rd_wdata = rvfi_rd_wdata;
         rec.mem_addr = rvfi_mem_addr;
         rec.rmask    = rvfi_mem_rmask;
         rec.wmask    = rvfi_mem_wmask;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni || flush_i) begin
         gap_cnt_q    <= '0;
         gap_order_q  <= '0;
         drop_total_o <= '0;
      end else begin
         if (drop && state_q == TRACE_CAPTURE) begin
            gap_cnt_q   <= DropCntWidth'(1);
            gap_order_q <= rvfi_order;
         end else if (drop) begin
            gap_cnt_q <= &gap_cnt_q ? gap_cnt_q : gap_cnt_q + 1'b1;
         end else if (push && state_q == TRACE_DROPPING) begin
            gap_cnt_q <= '0;
         end
         if (drop && !(&drop_total_o)) drop_total_o <= drop_total_o + 1'b1;
      end
   end

   ibex_trace_fifo #(
      .Depth (Depth),
      .T     (trace_rec_t)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .flush_i (flush_i),
      .push_i  (push),
      .wdata_i (rec),
      .pop_i   (pop),
      .rdata_o (trace_rec_o),
      .full_o  (full),
      .empty_o (empty),
      .fill_o  (fill_o)
   );

endmodule

// File: tb/tb_ibex_rvfi_trace_buffer.sv
// tb_ibex_rvfi_trace_buffer: directed bench with a scoreboard of expected output records.
module tb_ibex_rvfi_trace_buffer;
   import ibex_pkg::*;

   logic        clk_i = 0, rst_ni = 0, enable_i = 1, flush_i = 0, rvfi_valid = 0;
   logic [63:0] rvfi_order = '0;
   logic [31:0] rvfi_insn = '0, rvfi_pc_rdata = '0, rvfi_rd_wdata = '0, rvfi_mem_addr = '0;
   logic        rvfi_trap = 0, rvfi_intr = 0;
   logic [4:0]  rvfi_rd_addr = '0;
   logic [3:0]  rvfi_mem_rmask = '0, rvfi_mem_wmask = '0;
   logic        trace_valid_o, trace_ready_i = 0;
   trace_rec_t  trace_rec_o;
   logic [3:0]  fill_o;
   logic [31:0] drop_total_o;

   int          total = 0, bad = 0;
   trace_rec_t  exp_q[$];
   trace_rec_t  mon_exp;

   ibex_rvfi_trace_buffer #(.Depth(8), .DropCntWidth(16)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .enable_i(enable_i), .flush_i(flush_i),
      .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order), .rvfi_insn(rvfi_insn),
      .rvfi_trap(rvfi_trap), .rvfi_intr(rvfi_intr), .rvfi_pc_rdata(rvfi_pc_rdata),
      .rvfi_rd_addr(rvfi_rd_addr), .rvfi_rd_wdata(rvfi_rd_wdata), .rvfi_mem_addr(rvfi_mem_addr),
      .rvfi_mem_rmask(rvfi_mem_rmask), .rvfi_mem_wmask(rvfi_mem_wmask),
      .trace_valid_o(trace_valid_o), .trace_ready_i(trace_ready_i), .trace_rec_o(trace_rec_o),
      .fill_o(fill_o), .drop_total_o(drop_total_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic trace_rec_t ret_rec(logic [63:0] o);
      trace_rec_t r;
      r          = '0;
      r.kind     = TRACE_RETIRE;
      r.trap     = o[0];
      r.intr     = o[1];
      r.order    = o;
      r.pc       = 32'h8000_0000 + (o[31:0] << 2);
      r.insn     = 32'h0000_0013 ^ (o[31:0] << 7);
      r.rd_addr  = o[4:0];
      r.rd_wdata = ~o[31:0];
      r.mem_addr = 32'h1000_0000 | o[31:0];
      r.rmask    = o[3:0];
      r.wmask    = ~o[3:0];
      return r;
   endfunction

   function automatic trace_rec_t ovf_rec(logic [63:0] o, logic [31:0] cnt);
      trace_rec_t r;
      r          = '0;
      r.kind     = TRACE_OVERFLOW;
      r.order    = o;
      r.rd_wdata = cnt;
      return r;
   endfunction

   task automatic tick;
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic retire(logic [63:0] o, bit expect_out);
      trace_rec_t r;
      r              = ret_rec(o);
      rvfi_valid     = 1;
      rvfi_order     = r.order;
      rvfi_insn      = r.insn;
      rvfi_trap      = r.trap;
      rvfi_intr      = r.intr;
      rvfi_pc_rdata  = r.pc;
      rvfi_rd_addr   = r.rd_addr;
      rvfi_rd_wdata  = r.rd_wdata;
      rvfi_mem_addr  = r.mem_addr;
      rvfi_mem_rmask = r.rmask;
      rvfi_mem_wmask = r.wmask;
      if (expect_out) exp_q.push_back(r);
      tick;
   endtask

   task automatic drain(string tag);
      rvfi_valid    = 0;
      trace_ready_i = 1;
      for (int i = 0; i < 100 && exp_q.size() != 0; i++) tick;
      tick;
      chk({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
   endtask

   task automatic do_flush;
      flush_i = 1;
      tick;
      flush_i = 0;
   endtask

   always @(negedge clk_i) begin
      if (rst_ni && trace_valid_o && trace_ready_i) begin
         total++;
         assert (exp_q.size() != 0) else begin
            bad++;
            $error("FAIL unexpected_rec got=%h expected=none", trace_rec_o);
         end
         if (exp_q.size() != 0) begin
            mon_exp = exp_q.pop_front();
            total++;
            assert (trace_rec_o === mon_exp) else begin
               bad++;
               $error("FAIL rec got=%h expected=%h", trace_rec_o, mon_exp);
            end
         end
      end
   end

   initial begin
      repeat (2) tick;
      chk("rst_valid", 64'(trace_valid_o), 64'd0);
      chk("rst_rec", 64'(trace_rec_o != '0), 64'd0);
      chk("rst_fill", 64'(fill_o), 64'd0);
      chk("rst_drop", 64'(drop_total_o), 64'd0);
      rst_ni = 1;
      tick;

      // back-to-back retirements with the sink always ready
      trace_ready_i = 1;
      for (int i = 0; i < 20; i++) begin
         retire(64'(i), 1);
         total++;
         assert (fill_o <= 1) else begin
            bad++;
            $error("FAIL fill_le1 got=%0d expected<=1", fill_o);
         end
      end
      drain("b2b");
      chk("b2b_drop", 64'(drop_total_o), 64'd0);

      // overflow with idle recovery
      do_flush;
      trace_ready_i = 0;
      for (int i = 0; i < 11; i++) retire(64'(i), i < 8);
      chk("ovf_fill", 64'(fill_o), 64'd8);
      chk("ovf_drop", 64'(drop_total_o), 64'd3);
      exp_q.push_back(ovf_rec(64'd8, 32'd3));
      drain("ovf");

      // retirements keep arriving while the sink drains: all dropped, marker only on idle
      do_flush;
      trace_ready_i = 0;
      for (int i = 100; i < 108; i++) retire(64'(i), 1);
      retire(64'd108, 0);
      trace_ready_i = 1;
      for (int i = 109; i < 121; i++) retire(64'(i), 0);
      chk("busy_drop", 64'(drop_total_o), 64'd13);
      chk("busy_empty", 64'(trace_valid_o), 64'd0);
      exp_q.push_back(ovf_rec(64'd108, 32'd13));
      drain("busy");
      chk("busy_drop_after", 64'(drop_total_o), 64'd13);

      // flush with a concurrent retirement
      trace_ready_i = 0;
      for (int i = 300; i < 305; i++) retire(64'(i), 0);
      chk("fl_fill5", 64'(fill_o), 64'd5);
      flush_i = 1;
      retire(64'd305, 0);
      flush_i    = 0;
      rvfi_valid = 0;
      chk("fl_valid", 64'(trace_valid_o), 64'd0);
      chk("fl_fill", 64'(fill_o), 64'd0);
      chk("fl_drop", 64'(drop_total_o), 64'd0);
      trace_ready_i = 1;
      repeat (3) tick;
      chk("fl_not_stored", 64'(fill_o), 64'd0);

      // full FIFO, pop and push in the same cycle
      trace_ready_i = 0;
      for (int i = 200; i < 208; i++) retire(64'(i), 1);
      trace_ready_i = 1;
      retire(64'd208, 1);
      chk("pp_fill", 64'(fill_o), 64'd8);
      chk("pp_drop", 64'(drop_total_o), 64'd0);
      drain("pp");

      // long gap saturates the per-gap counter but not the total
      do_flush;
      trace_ready_i = 0;
      for (int i = 400; i < 408; i++) retire(64'(i), 1);
      for (int i = 0; i < 70000; i++) retire(64'(408 + i), 0);
      chk("sat_total", 64'(drop_total_o), 64'd70000);
      exp_q.push_back(ovf_rec(64'd408, 32'd65535));
      drain("sat");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
